// File: rtl/switch_mem_arb_if.sv
// Requester handshake, read-response and memory-side signal bundle for switch_mem_arb.
interface switch_mem_arb_if;
    logic       req0_valid;
    logic       req0_ready;
    logic       req0_rd_wr;
    logic [1:0] req0_add;
    logic [7:0] req0_data;
    logic       req1_valid;
    logic       req1_ready;
    logic       req1_rd_wr;
    logic [1:0] req1_add;
    logic [7:0] req1_data;
    logic       rsp0_valid;
    logic       rsp1_valid;
    logic [7:0] rsp_data;
    logic       mem_en;
    logic       mem_rd_wr;
    logic [1:0] mem_add;
    logic [7:0] mem_data;
    logic [7:0] mem_rdata;
    logic       busy;

    modport slave (
        input  req0_valid, req0_rd_wr, req0_add, req0_data,
        input  req1_valid, req1_rd_wr, req1_add, req1_data,
        input  mem_rdata,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data,
        output mem_en, mem_rd_wr, mem_add, mem_data, busy
    );

    modport master (
        output req0_valid, req0_rd_wr, req0_add, req0_data,
        output req1_valid, req1_rd_wr, req1_add, req1_data,
        output mem_rdata,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data,
        input  mem_en, mem_rd_wr, mem_add, mem_data, busy
    );
endinterface

// File: rtl/switch_mem_arb.sv
// Two-requester arbiter in front of a small register memory (IDLE/ACCESS/RD_WAIT/GAP).
// Define SWITCH_MEM_ARB_RR_EN for round-robin arbitration; default is fixed priority (req0 wins).
module switch_mem_arb (
    input  logic            clock,
    input  logic            reset_n,
    switch_mem_arb_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RD_WAIT, GAP} state_t;

    state_t     state;
    logic       owner;
    logic       grant0;
    logic       grant1;
    logic       take;
    logic       sel_rd_wr;
    logic [1:0] sel_add;
    logic [7:0] sel_data;

`ifdef SWITCH_MEM_ARB_RR_EN
    // last_grant holds the requester served most recently; the other one wins a tie.
    logic last_grant;
    always_comb begin
        grant0 = bus.req0_valid & (~bus.req1_valid | last_grant);
        grant1 = bus.req1_valid & (~bus.req0_valid | ~last_grant);
    end
`else
    always_comb begin
        grant0 = bus.req0_valid;
        grant1 = bus.req1_valid & ~bus.req0_valid;
    end
`endif

    // Ready is gated by reset so it drops immediately while reset_n is low.
    assign bus.req0_ready = reset_n & (state == IDLE) & grant0;
    assign bus.req1_ready = reset_n & (state == IDLE) & grant1;
    assign take           = reset_n & (state == IDLE) & (grant0 | grant1);

    always_comb begin
        sel_rd_wr = bus.req0_rd_wr;
        sel_add   = bus.req0_add;
        sel_data  = bus.req0_data;
        if (grant1) begin
            sel_rd_wr = bus.req1_rd_wr;
            sel_add   = bus.req1_add;
            sel_data  = bus.req1_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            owner          <= 1'b0;
            bus.mem_en     <= 1'b0;
            bus.mem_rd_wr  <= 1'b0;
            bus.mem_add    <= '0;
            bus.mem_data   <= '0;
            bus.rsp0_valid <= 1'b0;
            bus.rsp1_valid <= 1'b0;
            bus.rsp_data   <= '0;
            bus.busy       <= 1'b0;
`ifdef SWITCH_MEM_ARB_RR_EN
            last_grant     <= 1'b1;
`endif
        end else begin
            // Memory strobe and response pulses default low; only one state raises each.
            bus.mem_en     <= 1'b0;
            bus.mem_rd_wr  <= 1'b0;
            bus.mem_add    <= '0;
            bus.mem_data   <= '0;
            bus.rsp0_valid <= 1'b0;
            bus.rsp1_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (take) begin
                        bus.mem_en    <= 1'b1;
                        bus.mem_rd_wr <= sel_rd_wr;
                        bus.mem_add   <= sel_add;
                        bus.mem_data  <= sel_rd_wr ? sel_data : '0;
                        owner         <= grant1;
                        bus.busy      <= 1'b1;
                        state         <= ACCESS;
`ifdef SWITCH_MEM_ARB_RR_EN
                        last_grant    <= grant1;
`endif
                    end
                end
                ACCESS: begin
                    state <= bus.mem_rd_wr ? GAP : RD_WAIT;
                end
                RD_WAIT: begin
                    bus.rsp_data   <= bus.mem_rdata;
                    bus.rsp0_valid <= ~owner;
                    bus.rsp1_valid <= owner;
                    state          <= GAP;
                end
                GAP: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_switch_mem_arb.sv
// Randomized bench for switch_mem_arb with a cycle-schedule reference model and directed literal checks.
module tb_switch_mem_arb;
    localparam int NCYC = 8192;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    switch_mem_arb_if bus();

    switch_mem_arb dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference schedule: what each output must be in each cycle, filled in at handshake time.
    bit       e_men  [NCYC];
    bit       e_rw   [NCYC];
    bit [1:0] e_add  [NCYC];
    bit [7:0] e_data [NCYC];
    bit       e_busy [NCYC];
    int       e_rsp  [NCYC];
    bit [7:0] rlog   [NCYC];
    int       next_free = 0;
    int       last      = 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h cycle=%0d time=%0t", nm, act, exp, cyc, $time);
        end
    endtask

    // Compare process: model step plus full output check on every cycle.
    initial begin
        bit g0, g1, w, rw;
        int c;
        forever begin
            @(negedge clock);
            c  = cyc;
            g0 = 1'b0;
            g1 = 1'b0;
            if (c + 5 < NCYC) begin
                if (!reset_n) begin
                    for (int k = c; k < c + 5; k++) begin
                        e_men[k] = 0; e_rw[k] = 0; e_add[k] = 0;
                        e_data[k] = 0; e_busy[k] = 0; e_rsp[k] = 0;
                    end
                    next_free = c + 1;
                    last      = 1;
                end else if (c >= next_free) begin
                    if (bus.req0_valid && bus.req1_valid) begin
`ifdef SWITCH_MEM_ARB_RR_EN
                        if (last == 1) g0 = 1'b1; else g1 = 1'b1;
`else
                        g0 = 1'b1;
`endif
                    end else begin
                        g0 = bus.req0_valid;
                        g1 = bus.req1_valid;
                    end
                    if (g0 || g1) begin
                        w  = g1;
                        rw = w ? bus.req1_rd_wr : bus.req0_rd_wr;
                        e_men[c+1]  = 1;
                        e_rw[c+1]   = rw;
                        e_add[c+1]  = w ? bus.req1_add : bus.req0_add;
                        e_data[c+1] = rw ? (w ? bus.req1_data : bus.req0_data) : 8'h00;
                        e_busy[c+1] = 1;
                        e_busy[c+2] = 1;
                        if (rw) begin
                            next_free = c + 3;
                        end else begin
                            e_busy[c+3] = 1;
                            e_rsp[c+3]  = w ? 2 : 1;
                            next_free   = c + 4;
                        end
                        last = w ? 1 : 0;
                    end
                end
                chk("req0_ready", bus.req0_ready, g0);
                chk("req1_ready", bus.req1_ready, g1);
                chk("mem_en",     bus.mem_en,     e_men[c]);
                chk("mem_rd_wr",  bus.mem_rd_wr,  e_rw[c]);
                chk("mem_add",    bus.mem_add,    e_add[c]);
                chk("mem_data",   bus.mem_data,   e_data[c]);
                chk("busy",       bus.busy,       e_busy[c]);
                chk("rsp0_valid", bus.rsp0_valid, e_rsp[c] == 1);
                chk("rsp1_valid", bus.rsp1_valid, e_rsp[c] == 2);
                if (e_rsp[c] != 0)
                    chk("rsp_data", bus.rsp_data, rlog[c-1]);
                if (!reset_n)
                    chk("rsp_data_rst", bus.rsp_data, 0);
                rlog[c] = bus.mem_rdata;
            end
            cyc++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic neg();
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic rnd_req(input bit hs, input logic v_i, input logic rw_i, input logic [1:0] a_i,
                           input logic [7:0] d_i, output logic v_o, output logic rw_o,
                           output logic [1:0] a_o, output logic [7:0] d_o);
        v_o = v_i; rw_o = rw_i; a_o = a_i; d_o = d_i;
        if (hs || !v_i) begin
            v_o  = ($urandom_range(0, 99) < 45);
            rw_o = 1'($urandom_range(0, 1));
            a_o  = 2'($urandom_range(0, 3));
            d_o  = 8'($urandom_range(0, 255));
        end else begin
            if ($urandom_range(0, 9) == 0) v_o = 1'b0;
            if ($urandom_range(0, 4) == 0) begin
                rw_o = 1'($urandom_range(0, 1));
                a_o  = 2'($urandom_range(0, 3));
                d_o  = 8'($urandom_range(0, 255));
            end
        end
    endtask

    initial begin
        int   gseq[16];
        int   ng;
        bit   hs0, hs1;
        logic v, rw;
        logic [1:0] a;
        logic [7:0] d;

        bus.req0_valid = 1'b1; bus.req0_rd_wr = 1'b1; bus.req0_add = 2'd0; bus.req0_data = 8'h00;
        bus.req1_valid = 1'b0; bus.req1_rd_wr = 1'b0; bus.req1_add = 2'd0; bus.req1_data = 8'h00;
        bus.mem_rdata  = 8'h3C;

        // Reset state, including ready held low despite a pending request.
        repeat (2) neg();
        chk("rst_req0_ready", bus.req0_ready, 0);
        chk("rst_busy",       bus.busy,       0);
        chk("rst_mem_en",     bus.mem_en,     0);
        chk("rst_rsp_data",   bus.rsp_data,   0);
        step();
        bus.req0_valid = 1'b0;
        reset_n = 1'b1;
        idle(3);

        // req0 write add=2 data=A5.
        bus.req0_valid = 1'b1; bus.req0_rd_wr = 1'b1; bus.req0_add = 2'd2; bus.req0_data = 8'hA5;
        neg(); chk("wr_ready0", bus.req0_ready, 1);
        step(); bus.req0_valid = 1'b0;
        neg();
        chk("wr_mem_en",   bus.mem_en,    1);
        chk("wr_mem_rdwr", bus.mem_rd_wr, 1);
        chk("wr_mem_add",  bus.mem_add,   2);
        chk("wr_mem_data", bus.mem_data,  8'hA5);
        chk("wr_busy1",    bus.busy,      1);
        step(); neg();
        chk("wr_gap_en",   bus.mem_en, 0);
        chk("wr_busy2",    bus.busy,   1);
        step(); neg();
        chk("wr_busy_end", bus.busy, 0);
        idle(2);

        // Fields change after the handshake; the latched value must be used.
        bus.req0_valid = 1'b1; bus.req0_rd_wr = 1'b1; bus.req0_add = 2'd3; bus.req0_data = 8'h11;
        neg(); chk("hold_ready0", bus.req0_ready, 1);
        step(); bus.req0_data = 8'h22; bus.req0_valid = 1'b0;
        neg(); chk("hold_mem_data", bus.mem_data, 8'h11);
        idle(3);

        // req1 read add=1 with mem_rdata=3C.
        bus.req1_valid = 1'b1; bus.req1_rd_wr = 1'b0; bus.req1_add = 2'd1; bus.req1_data = 8'hFF;
        neg(); chk("rd_ready1", bus.req1_ready, 1);
        step(); bus.req1_valid = 1'b0;
        neg();
        chk("rd_mem_en",   bus.mem_en,    1);
        chk("rd_mem_rdwr", bus.mem_rd_wr, 0);
        chk("rd_mem_add",  bus.mem_add,   1);
        chk("rd_mem_data", bus.mem_data,  0);
        step(); neg();
        step(); neg();
        chk("rd_rsp1_valid", bus.rsp1_valid, 1);
        chk("rd_rsp_data",   bus.rsp_data,   8'h3C);
        chk("rd_rsp0_valid", bus.rsp0_valid, 0);
        step(); neg();
        chk("rd_rsp1_once",  bus.rsp1_valid, 0);
        idle(2);

        // Both requesters writing continuously.
        bus.req0_valid = 1'b1; bus.req0_rd_wr = 1'b1; bus.req0_add = 2'd0; bus.req0_data = 8'h50;
        bus.req1_valid = 1'b1; bus.req1_rd_wr = 1'b1; bus.req1_add = 2'd1; bus.req1_data = 8'h60;
        ng = 0;
        for (int i = 0; i < 13; i++) begin
            neg();
            if (bus.req0_ready && ng < 16) begin gseq[ng] = 0; ng++; end
            if (bus.req1_ready && ng < 16) begin gseq[ng] = 1; ng++; end
            step();
        end
        idle(3);
        chk("grant_count", ng >= 4, 1);
        if (ng >= 4) begin
            for (int i = 0; i < 4; i++) begin
`ifdef SWITCH_MEM_ARB_RR_EN
                chk("grant_seq", gseq[i], i % 2);
`else
                chk("grant_seq", gseq[i], 0);
`endif
            end
        end

        // Reset during RD_WAIT aborts the read and re-arms req0 priority.
        bus.req0_valid = 1'b1; bus.req0_rd_wr = 1'b0; bus.req0_add = 2'd0;
        neg(); chk("abort_ready0", bus.req0_ready, 1);
        step(); bus.req0_valid = 1'b0;
        step();
        reset_n = 1'b0;
        #1;
        chk("abort_mem_en",   bus.mem_en,   0);
        chk("abort_busy",     bus.busy,     0);
        chk("abort_rsp0",     bus.rsp0_valid, 0);
        chk("abort_rsp_data", bus.rsp_data, 0);
        step();
        reset_n = 1'b1;
        repeat (5) begin
            neg(); chk("abort_no_rsp0", bus.rsp0_valid, 0);
            step();
        end
        bus.req0_valid = 1'b1; bus.req0_rd_wr = 1'b1; bus.req0_data = 8'h77;
        bus.req1_valid = 1'b1; bus.req1_rd_wr = 1'b1; bus.req1_data = 8'h88;
        neg();
        chk("post_rst_ready0", bus.req0_ready, 1);
        chk("post_rst_ready1", bus.req1_ready, 0);
        step();
        idle(4);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 2000; i++) begin
            neg();
            hs0 = bus.req0_valid & bus.req0_ready;
            hs1 = bus.req1_valid & bus.req1_ready;
            step();
            bus.mem_rdata = 8'($urandom);
            if (!reset_n) begin
                if ($urandom_range(0, 1) == 0) reset_n = 1'b1;
            end else if ($urandom_range(0, 299) == 0) begin
                reset_n = 1'b0;
            end
            rnd_req(hs0, bus.req0_valid, bus.req0_rd_wr, bus.req0_add, bus.req0_data, v, rw, a, d);
            bus.req0_valid = v; bus.req0_rd_wr = rw; bus.req0_add = a; bus.req0_data = d;
            rnd_req(hs1, bus.req1_valid, bus.req1_rd_wr, bus.req1_add, bus.req1_data, v, rw, a, d);
            bus.req1_valid = v; bus.req1_rd_wr = rw; bus.req1_add = a; bus.req1_data = d;
        end
        reset_n = 1'b1;
        idle(6);
        neg();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
